// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, then shifts one command
// byte with odd parity out on device clock falls and checks the device ACK.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES       = 6000,
    parameter int unsigned START_TIMEOUT_CYCLES = 750000,
    parameter int unsigned XFER_TIMEOUT_CYCLES  = 100000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] the_command,
    input  logic       send_command,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT,
    output logic       busy,
    output logic       command_was_sent,
    output logic       error_communication_timed_out,
    output logic       error_no_ack
);

    localparam int unsigned MaxCycles =
        (INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ?
        ((INHIBIT_CYCLES > XFER_TIMEOUT_CYCLES) ? INHIBIT_CYCLES : XFER_TIMEOUT_CYCLES) :
        ((START_TIMEOUT_CYCLES > XFER_TIMEOUT_CYCLES) ? START_TIMEOUT_CYCLES
                                                      : XFER_TIMEOUT_CYCLES);
    localparam int TimerW = $clog2(MaxCycles + 1);

    typedef enum logic [3:0] {
        StIdle, StInhibit, StRts, StWaitStart, StData,
        StWaitAck, StWaitIdle, StErrTo, StErrNoack
    } state_e;

    state_e            state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [3:0]        bit_idx_q, bit_idx_d;
    logic [8:0]        frame_q, frame_d;
    logic              done_q, done_d;
    logic              clk_meta_q, clk_sync_q, clk_prev_q;
    logic              dat_meta_q, dat_sync_q;
    logic              fall;
    logic              clk_low, dat_low;
    logic              xfer_expired;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            bit_idx_q  <= '0;
            frame_q    <= '0;
            done_q     <= 1'b0;
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            frame_q    <= frame_d;
            done_q     <= done_d;
            clk_meta_q <= PS2_CLK;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            dat_meta_q <= PS2_DAT;
            dat_sync_q <= dat_meta_q;
        end
    end

    assign fall         = clk_prev_q & ~clk_sync_q;
    assign xfer_expired = timer_q >= TimerW'(XFER_TIMEOUT_CYCLES - 1);

    always_comb begin
        state_d   = state_q;
        timer_d   = (timer_q != {TimerW{1'b1}}) ? timer_q + 1'b1 : timer_q;
        bit_idx_d = bit_idx_q;
        frame_d   = frame_q;
        done_d    = 1'b0;
        case (state_q)
            StIdle: begin
                timer_d = '0;
                // A request coinciding with the done pulse is dropped, like one made while busy.
                if (send_command && !done_q) begin
                    frame_d   = {~^the_command, the_command};
                    bit_idx_d = '0;
                    state_d   = StInhibit;
                end
            end
            StInhibit: begin
                if (timer_q >= TimerW'(INHIBIT_CYCLES - 1)) begin
                    state_d = StRts;
                end
            end
            StRts: begin
                timer_d = '0;
                state_d = StWaitStart;
            end
            StWaitStart: begin
                if (fall) begin
                    timer_d   = '0;
                    bit_idx_d = '0;
                    state_d   = StData;
                end else if (timer_q >= TimerW'(START_TIMEOUT_CYCLES - 1)) begin
                    state_d = StErrTo;
                end
            end
            StData: begin
                if (fall) begin
                    if (bit_idx_q == 4'd8) begin
                        state_d = StWaitAck;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end else if (xfer_expired) begin
                    state_d = StErrTo;
                end
            end
            StWaitAck: begin
                if (fall) begin
                    state_d = dat_sync_q ? StErrNoack : StWaitIdle;
                end else if (xfer_expired) begin
                    state_d = StErrTo;
                end
            end
            StWaitIdle: begin
                if (clk_sync_q && dat_sync_q) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (xfer_expired) begin
                    state_d = StErrTo;
                end
            end
            StErrTo, StErrNoack: state_d = StIdle;
            default:             state_d = StIdle;
        endcase
    end

    // DATA drives bit_idx_q of the frame; once past parity the stop bit is simply released.
    assign clk_low = (state_q == StInhibit) || (state_q == StRts);
    assign dat_low = (state_q == StRts) || (state_q == StWaitStart) ||
                     ((state_q == StData) && !frame_q[bit_idx_q]);

    assign PS2_CLK = clk_low ? 1'b0 : 1'bz;
    assign PS2_DAT = dat_low ? 1'b0 : 1'bz;

    assign busy                          = (state_q != StIdle);
    assign command_was_sent              = done_q;
    assign error_communication_timed_out = (state_q == StErrTo);
    assign error_no_ack                  = (state_q == StErrNoack);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the host and every
// transaction is compared against a frame/outcome model derived from the protocol rules.
module tb_ps2_host_tx;

    localparam int unsigned Inh     = 20;
    localparam int unsigned StartTo = 200;
    localparam int unsigned XferTo  = 2000;

    logic       clk          = 1'b0;
    logic       reset        = 1'b1;
    logic       send_command = 1'b0;
    logic [7:0] the_command  = 8'h00;
    logic       dev_clk_low  = 1'b0;
    logic       dev_dat_low  = 1'b0;
    logic       busy, done, err_to, err_noack;
    wire        ps2_clk, ps2_dat;

    pullup (ps2_clk);
    pullup (ps2_dat);
    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES      (Inh),
        .START_TIMEOUT_CYCLES(StartTo),
        .XFER_TIMEOUT_CYCLES (XferTo)
    ) dut (
        .CLOCK_50                     (clk),
        .reset                        (reset),
        .the_command                  (the_command),
        .send_command                 (send_command),
        .PS2_CLK                      (ps2_clk),
        .PS2_DAT                      (ps2_dat),
        .busy                         (busy),
        .command_was_sent             (done),
        .error_communication_timed_out(err_to),
        .error_no_ack                 (err_noack)
    );

    int checks = 0;
    int errors = 0;
    int n_done = 0, n_to = 0, n_noack = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pulse monitor: counts every pulse; pulses must be mutually exclusive, busy low at done.
    always @(negedge clk) begin
        if (done || err_to || err_noack) begin
            check("one_pulse", 32'(done) + 32'(err_to) + 32'(err_noack), 32'd1);
            if (done) begin
                n_done++;
                check("busy_at_done", 32'(busy), 32'd0);
            end
            if (err_to)    n_to++;
            if (err_noack) n_noack++;
        end
    end

    // Reference model: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] frame_bits(input logic [7:0] b);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
        f[9]  = ($countones(b) % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    function automatic void outcome(input int nclocks, input bit ack,
                                    output bit d, output bit t, output bit n);
        d = (nclocks >= 11) && ack;
        n = (nclocks >= 11) && !ack;
        t = (nclocks < 11);
    endfunction

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        the_command  = b;
        send_command = 1'b1;
        @(negedge clk);
        send_command = 1'b0;
    endtask

    task automatic measure_inhibit();
        int  inh = 0;
        bit  ok  = 0;
        for (int c = 0; c < 200 && !ok; c++) begin
            if (ps2_clk === 1'b0 && ps2_dat === 1'b1) inh++;
            if (ps2_clk === 1'b1 && ps2_dat === 1'b0 && inh > 0) ok = 1;
            else @(negedge clk);
        end
        check("rts_reached", 32'(ok), 32'd1);
        check("inhibit_len", inh, Inh);
    endtask

    // Device: clocks nclocks times (~40-cycle halves), samples DAT before the first fall and at
    // each rising edge, drives ACK on clock 11 when ack=1; optionally pokes send_command.
    task automatic run_device(input int nclocks, input bit ack, input int poke_at,
                              input logic [7:0] poke_val, output logic [10:0] bits);
        bits    = '0;
        bits[0] = ps2_dat;
        for (int i = 1; i <= nclocks; i++) begin
            repeat (10) @(negedge clk);
            if (i == 11 && ack) begin
                dev_dat_low = 1'b1;
                repeat (5) @(negedge clk);
            end
            if (i == poke_at) begin
                the_command  = poke_val;
                send_command = 1'b1;
                @(negedge clk);
                send_command = 1'b0;
            end
            dev_clk_low = 1'b1;
            repeat (40) @(negedge clk);
            if (i <= 10) bits[i] = ps2_dat;
            dev_clk_low = 1'b0;
            repeat (30) @(negedge clk);
            if (i == 11) dev_dat_low = 1'b0;
        end
    endtask

    task automatic run_txn(input logic [7:0] cmd, input int nclocks, input bit ack,
                           input int poke_at, input bit exp_d, input bit exp_t, input bit exp_n);
        int          bd = n_done, bt = n_to, bn = n_noack;
        logic [10:0] bits;
        bit          seen = 0;
        send(cmd);
        measure_inhibit();
        run_device(nclocks, ack, poke_at, ~cmd, bits);
        for (int c = 0; c < 3000 && !seen; c++) begin
            if (n_done + n_to + n_noack > bd + bt + bn) seen = 1;
            else @(negedge clk);
        end
        check("pulse_seen", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        if (nclocks == 11) check("frame_bits", 32'(bits), 32'(frame_bits(cmd)));
        check("n_done", n_done - bd, 32'(exp_d));
        check("n_timeout", n_to - bt, 32'(exp_t));
        check("n_noack", n_noack - bn, 32'(exp_n));
        check("busy_after", 32'(busy), 32'd0);
        check("lines_idle", {30'd0, ps2_clk, ps2_dat}, 32'd3);
        repeat (20) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] cmd;
        int         nclocks;
        bit         ack;
        int         poke_at;
        bit         exp_d;
        bit         exp_t;
        bit         exp_n;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [10:0] dummy;
        int          bd, bt, bn;
        vecs[0] = '{8'hED, 11, 1'b1, 0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'hF4, 11, 1'b1, 0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'hFF, 11, 1'b1, 0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h00, 0,  1'b0, 0, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'hAA, 11, 1'b0, 0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{8'h55, 5,  1'b0, 0, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{8'hF0, 11, 1'b1, 3, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{8'hF3, 10, 1'b0, 0, 1'b0, 1'b1, 1'b0};

        repeat (5) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pulses", {29'd0, done, err_to, err_noack}, 32'd0);
        check("rst_lines", {30'd0, ps2_clk, ps2_dat}, 32'd3);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            run_txn(vecs[v].cmd, vecs[v].nclocks, vecs[v].ack, vecs[v].poke_at,
                    vecs[v].exp_d, vecs[v].exp_t, vecs[v].exp_n);
        end

        for (int r = 0; r < 5; r++) begin
            logic [7:0] b;
            int         nc;
            bit         ack, d, t, n;
            b   = 8'($urandom);
            nc  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : 11;
            ack = 1'($urandom_range(0, 3) != 0);
            outcome(nc, ack, d, t, n);
            run_txn(b, nc, ack, 0, d, t, n);
        end

        // Reset during the fifth data bit (data[4] = 0, so the host is pulling DAT low).
        bd = n_done; bt = n_to; bn = n_noack;
        send(8'h0C);
        measure_inhibit();
        run_device(4, 1'b0, 0, 8'h00, dummy);
        repeat (10) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (20) @(negedge clk);
        check("bit4_driven_low", 32'(ps2_dat), 32'd0);
        reset       = 1'b1;
        dev_clk_low = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_lines", {30'd0, ps2_clk, ps2_dat}, 32'd3);
        reset = 1'b0;
        repeat (2500) @(negedge clk);
        check("midrst_no_pulse", (n_done - bd) + (n_to - bt) + (n_noack - bn), 32'd0);
        run_txn(8'hED, 11, 1'b1, 0, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
